// File: rtl/measure_ctrl_pkg.sv
// Shared types and constants for the measurement sequencer.
// Holds the FSM state encoding and default sizing.
package measure_ctrl_pkg;

  localparam int FLUSH_CYCLES     = 2;
  localparam int ACC_W_DEF        = 40;
  localparam int AVG_LOG2_MAX_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/measure_ctrl.sv
// Measurement sequencer: flushes the datapath, accumulates
// 2^n samples, then presents the sums over a valid/ready port.
module measure_ctrl
  import measure_ctrl_pkg::*;
#(
  parameter int ACC_W        = ACC_W_DEF,
  parameter int AVG_LOG2_MAX = AVG_LOG2_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  input  logic             cfg_abort_i,
  input  logic [31:0]      cfg_gate_time_i,
  input  logic [2:0]       cfg_avg_log2_i,
  input  logic [31:0]      cfg_timeout_i,
  output logic             meas_en_o,
  output logic [31:0]      meas_gate_time_o,
  input  logic             meas_wr_en_i,
  input  logic [63:0]      meas_wr_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_sig_o,
  output logic [ACC_W-1:0] res_ref_o,
  output logic [7:0]       res_rounds_o,
  output logic             sts_busy_o,
  output logic             sts_timeout_o
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       flush_q;
  logic [31:0]      gate_q;
  logic [7:0]       tgt_q;
  logic [31:0]      to_lim_q;
  logic [31:0]      to_cnt_q;
  logic [7:0]       rnd_q;
  logic [ACC_W-1:0] sig_q;
  logic [ACC_W-1:0] ref_q;
  logic             tmo_q;

  logic [2:0]       avg_sat;
  logic [7:0]       tgt_d;
  logic             start_ok;
  logic             sample;
  logic             to_hit;

  assign avg_sat = (int'(cfg_avg_log2_i) > AVG_LOG2_MAX)
                 ? 3'(AVG_LOG2_MAX) : cfg_avg_log2_i;
  assign tgt_d   = 8'd1 << avg_sat;

  assign start_ok = (state_q == ST_IDLE) && cfg_start_i
                 && !cfg_abort_i;

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    to_hit  = 1'b0;
    if (cfg_abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_start_i) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_q == 2'(FLUSH_CYCLES - 1))
            state_d = ST_RUN;
        end
        ST_RUN: begin
          // a sample in the expiry cycle beats the timeout
          if (meas_wr_en_i) begin
            sample = 1'b1;
            if (rnd_q + 8'd1 == tgt_q) state_d = ST_DONE;
          end else if (to_lim_q != '0 &&
                       to_cnt_q == to_lim_q - 32'd1) begin
            to_hit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (res_ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      flush_q  <= '0;
      gate_q   <= '0;
      tgt_q    <= '0;
      to_lim_q <= '0;
      to_cnt_q <= '0;
      rnd_q    <= '0;
      sig_q    <= '0;
      ref_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        gate_q   <= cfg_gate_time_i;
        tgt_q    <= tgt_d;
        to_lim_q <= cfg_timeout_i;
        rnd_q    <= '0;
        sig_q    <= '0;
        ref_q    <= '0;
        tmo_q    <= 1'b0;
        flush_q  <= '0;
      end else if (state_q == ST_FLUSH) begin
        flush_q <= flush_q + 2'd1;
      end
      if (state_q == ST_FLUSH) begin
        to_cnt_q <= '0;
      end else if (sample) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        to_cnt_q <= to_cnt_q + 32'd1;
      end
      if (sample) begin
        sig_q <= sig_q + {{(ACC_W-32){1'b0}},
                          meas_wr_data_i[31:0]};
        ref_q <= ref_q + {{(ACC_W-32){1'b0}},
                          meas_wr_data_i[63:32]};
        rnd_q <= rnd_q + 8'd1;
      end
      if (to_hit) tmo_q <= 1'b1;
    end
  end

  assign meas_en_o        = (state_q == ST_RUN);
  assign meas_gate_time_o = gate_q;
  assign res_valid_o      = (state_q == ST_DONE);
  assign res_sig_o        = sig_q;
  assign res_ref_o        = ref_q;
  assign res_rounds_o     = rnd_q;
  assign sts_busy_o       = (state_q != ST_IDLE);
  assign sts_timeout_o    = tmo_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// Scoreboard bench for measure_ctrl: driver queues expected
// sums, a negedge monitor checks each result handshake.
module tb_measure_ctrl;

  localparam int ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             cfg_start_i;
  logic             cfg_abort_i;
  logic [31:0]      cfg_gate_time_i;
  logic [2:0]       cfg_avg_log2_i;
  logic [31:0]      cfg_timeout_i;
  logic             meas_en_o;
  logic [31:0]      meas_gate_time_o;
  logic             meas_wr_en_i;
  logic [63:0]      meas_wr_data_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [ACC_W-1:0] res_sig_o;
  logic [ACC_W-1:0] res_ref_o;
  logic [7:0]       res_rounds_o;
  logic             sts_busy_o;
  logic             sts_timeout_o;

  typedef struct packed {
    logic [ACC_W-1:0] sig;
    logic [ACC_W-1:0] rf;
    logic [7:0]       rnd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  measure_ctrl #(.ACC_W(ACC_W), .AVG_LOG2_MAX(7)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cfg_start_i     (cfg_start_i),
    .cfg_abort_i     (cfg_abort_i),
    .cfg_gate_time_i (cfg_gate_time_i),
    .cfg_avg_log2_i  (cfg_avg_log2_i),
    .cfg_timeout_i   (cfg_timeout_i),
    .meas_en_o       (meas_en_o),
    .meas_gate_time_o(meas_gate_time_o),
    .meas_wr_en_i    (meas_wr_en_i),
    .meas_wr_data_i  (meas_wr_data_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_sig_o       (res_sig_o),
    .res_ref_o       (res_ref_o),
    .res_rounds_o    (res_rounds_o),
    .sts_busy_o      (sts_busy_o),
    .sts_timeout_o   (sts_timeout_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid_o && exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_valid actual=1 required=0");
      end else if (res_valid_o && res_ready_i) begin
        e = exp_q.pop_front();
        chk("sb_sig", 64'(res_sig_o), 64'(e.sig));
        chk("sb_ref", 64'(res_ref_o), 64'(e.rf));
        chk("sb_rounds", 64'(res_rounds_o), 64'(e.rnd));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_vals;
    chk("rst_en", 64'(meas_en_o), 0);
    chk("rst_gate", 64'(meas_gate_time_o), 0);
    chk("rst_valid", 64'(res_valid_o), 0);
    chk("rst_sig", 64'(res_sig_o), 0);
    chk("rst_ref", 64'(res_ref_o), 0);
    chk("rst_rounds", 64'(res_rounds_o), 0);
    chk("rst_busy", 64'(sts_busy_o), 0);
    chk("rst_tmo", 64'(sts_timeout_o), 0);
  endtask

  task automatic start_to_run(input logic [31:0] gate,
                              input logic [2:0] avg,
                              input logic [31:0] to,
                              input bit scramble);
    cfg_gate_time_i = gate;
    cfg_avg_log2_i  = avg;
    cfg_timeout_i   = to;
    cfg_start_i     = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    chk("flush1_en", 64'(meas_en_o), 0);
    chk("flush1_busy", 64'(sts_busy_o), 1);
    if (scramble) begin
      cfg_gate_time_i = $urandom;
      cfg_avg_log2_i  = 3'($urandom);
      cfg_timeout_i   = 32'd1;
    end
    tick();
    chk("flush2_en", 64'(meas_en_o), 0);
    tick();
    chk("run_en", 64'(meas_en_o), 1);
    chk("run_gate", 64'(meas_gate_time_o), 64'(gate));
  endtask

  task automatic finish_done(input exp_t e, input int hold);
    chk("lat_valid", 64'(res_valid_o), 1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 64'(res_valid_o), 1);
      chk("hold_sig", 64'(res_sig_o), 64'(e.sig));
      chk("hold_ref", 64'(res_ref_o), 64'(e.rf));
      meas_wr_en_i   = 1'($urandom_range(0, 1));
      meas_wr_data_i = {$urandom, $urandom};
      tick();
      meas_wr_en_i = 1'b0;
    end
    if (hold > 0) begin
      chk("hold_end_sig", 64'(res_sig_o), 64'(e.sig));
      chk("hold_end_rnd", 64'(res_rounds_o), 64'(e.rnd));
    end
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("hs_idle_busy", 64'(sts_busy_o), 0);
    chk("hs_idle_valid", 64'(res_valid_o), 0);
  endtask

  // mode 0: random data, 1: all ones, 2: ref=1000 sig=50
  task automatic run_seq(input logic [31:0] gate,
                         input logic [2:0] avg,
                         input logic [31:0] to,
                         input int mode,
                         input int hold,
                         input bit scramble);
    int          n;
    logic [63:0] d[$];
    logic [63:0] s;
    exp_t        e;
    n = 1 << avg;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (mode == 1)      s = '1;
      else if (mode == 2) s = {32'd1000, 32'd50};
      else                s = {$urandom, $urandom};
      d.push_back(s);
      e.sig = e.sig + {8'h0, s[31:0]};
      e.rf  = e.rf + {8'h0, s[63:32]};
    end
    e.rnd = 8'(n);
    start_to_run(gate, avg, to, scramble);
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (mode == 0) ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        cfg_start_i = 1'($urandom_range(0, 1));
        tick();
        cfg_start_i = 1'b0;
      end
      if (i == n - 1)
        chk("pre_last_valid", 64'(res_valid_o), 0);
      meas_wr_en_i   = 1'b1;
      meas_wr_data_i = d[i];
      tick();
      meas_wr_en_i = 1'b0;
    end
    chk("done_gate", 64'(meas_gate_time_o), 64'(gate));
    chk("done_tmo", 64'(sts_timeout_o), 0);
    finish_done(e, hold);
  endtask

  initial begin
    exp_t e;
    rst_i           = 1'b1;
    cfg_start_i     = 1'b0;
    cfg_abort_i     = 1'b0;
    cfg_gate_time_i = '0;
    cfg_avg_log2_i  = '0;
    cfg_timeout_i   = '0;
    meas_wr_en_i    = 1'b0;
    meas_wr_data_i  = '0;
    res_ready_i     = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk_reset_vals();

    run_seq(32'd100, 3'd2, 32'd0, 2, 0, 1'b0);
    run_seq($urandom, 3'd7, 32'd0, 1, 2, 1'b0);

    // timeout with no samples
    start_to_run(32'd77, 3'd2, 32'd50, 1'b0);
    repeat (49) tick();
    chk("to_pre_busy", 64'(sts_busy_o), 1);
    chk("to_pre_flag", 64'(sts_timeout_o), 0);
    tick();
    chk("to_flag", 64'(sts_timeout_o), 1);
    chk("to_busy", 64'(sts_busy_o), 0);
    chk("to_en", 64'(meas_en_o), 0);

    // sample in the expiry cycle wins
    start_to_run(32'd5, 3'd1, 32'd5, 1'b0);
    chk("win_clr_flag", 64'(sts_timeout_o), 0);
    repeat (4) tick();
    e = '0;
    e.sig = 40'd11;
    e.rf  = 40'd22 + 40'd44;
    e.sig = e.sig + 40'd33;
    e.rnd = 8'd2;
    exp_q.push_back(e);
    meas_wr_en_i   = 1'b1;
    meas_wr_data_i = {32'd22, 32'd11};
    tick();
    meas_wr_en_i = 1'b0;
    chk("win_busy", 64'(sts_busy_o), 1);
    chk("win_flag", 64'(sts_timeout_o), 0);
    repeat (2) tick();
    meas_wr_en_i   = 1'b1;
    meas_wr_data_i = {32'd44, 32'd33};
    tick();
    meas_wr_en_i = 1'b0;
    finish_done(e, 0);

    // abort mid-run, then a fresh run
    start_to_run(32'd9, 3'd2, 32'd0, 1'b0);
    meas_wr_en_i   = 1'b1;
    meas_wr_data_i = {32'd7, 32'd9};
    tick();
    meas_wr_en_i = 1'b0;
    cfg_abort_i  = 1'b1;
    meas_wr_en_i = 1'b1;
    tick();
    cfg_abort_i  = 1'b0;
    meas_wr_en_i = 1'b0;
    chk("abort_en", 64'(meas_en_o), 0);
    chk("abort_busy", 64'(sts_busy_o), 0);
    chk("abort_valid", 64'(res_valid_o), 0);
    run_seq(32'd9, 3'd2, 32'd0, 0, 0, 1'b0);

    cfg_start_i = 1'b1;
    cfg_abort_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    cfg_abort_i = 1'b0;
    chk("abort_beats_start", 64'(sts_busy_o), 0);

    run_seq($urandom, 3'd3, 32'd0, 0, 20, 1'b1);

    // reset mid-run
    start_to_run(32'd55, 3'd3, 32'd0, 1'b0);
    meas_wr_en_i   = 1'b1;
    meas_wr_data_i = {32'd3, 32'd4};
    tick();
    rst_i = 1'b1;
    tick();
    rst_i        = 1'b0;
    meas_wr_en_i = 1'b0;
    chk_reset_vals();

    for (int k = 0; k < 12; k++) begin
      logic [31:0] to;
      to = ($urandom_range(0, 1) == 0)
         ? 32'd0 : 32'($urandom_range(8, 200));
      run_seq($urandom, 3'($urandom_range(0, 5)), to, 0,
              $urandom_range(0, 4), 1'b1);
    end

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
